inst_fetch: RTL



---
 rtl/growl_pkg.sv | 17 +
 rtl/inst_fetch_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/inst_fetch.sv | 98 +++++++++
 4 files changed

// File: rtl/growl_pkg.sv
// Shared AVR fetch constants and the two-word opcode decode used by inst_fetch.
// The INST_FETCH_SKIP_EN build option does not touch this package.
package growl_pkg;

    localparam logic [15:0] NOP_INST       = 16'h0000;
    localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

    // LDS/STS and JMP/CALL carry a second 16-bit word.
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_STS_MATCH) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_MATCH);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Program-memory and pipeline-side signals of the fetch stage.
// c_skip exists only when INST_FETCH_SKIP_EN is defined.
interface inst_fetch_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] pmem_adr;
    logic            pmem_re;
    logic [15:0]     pmem_dout;
    logic            c_stall;
    logic            c_pc_load;
    logic [PC_W-1:0] pc_load_val;
`ifdef INST_FETCH_SKIP_EN
    logic            c_skip;
`endif
    logic [15:0]     inst_out;
    logic [15:0]     inst2_out;
    logic            inst_two_word;
    logic            inst_valid;
    logic [PC_W-1:0] pc_out;

`ifdef INST_FETCH_SKIP_EN
    modport master (
        output pmem_adr, pmem_re, inst_out, inst2_out, inst_two_word, inst_valid, pc_out,
        input  pmem_dout, c_stall, c_pc_load, pc_load_val, c_skip
    );
    modport slave (
        input  pmem_adr, pmem_re, inst_out, inst2_out, inst_two_word, inst_valid, pc_out,
        output pmem_dout, c_stall, c_pc_load, pc_load_val, c_skip
    );
`else
    modport master (
        output pmem_adr, pmem_re, inst_out, inst2_out, inst_two_word, inst_valid, pc_out,
        input  pmem_dout, c_stall, c_pc_load, pc_load_val
    );
    modport slave (
        input  pmem_adr, pmem_re, inst_out, inst2_out, inst_two_word, inst_valid, pc_out,
        output pmem_dout, c_stall, c_pc_load, pc_load_val
    );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of instruction words, each tagged with its word address.
// Head and head+1 are visible so a two-word instruction can be presented at once.
module fetch_fifo #(
    parameter  int DEPTH = 3,
    parameter  int PC_W  = 16,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [15:0]     push_data,
    input  logic [PC_W-1:0] push_addr,
    input  logic [1:0]      pop_n,
    output logic [15:0]     head_data,
    output logic [PC_W-1:0] head_addr,
    output logic [15:0]     next_data,
    output logic [CW-1:0]   count
);

    logic [15:0]     mem_data [DEPTH];
    logic [PC_W-1:0] mem_addr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   next_idx;
    logic [CW-1:0]   count_q;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_add(wr_ptr, 1);
            rd_ptr  <= ptr_add(rd_ptr, int'(pop_n));
            count_q <= count_q + CW'(push) - CW'(pop_n);
        end
    end

    // Storage needs no reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem_data[wr_ptr] <= push_data;
            mem_addr[wr_ptr] <= push_addr;
        end
    end

    assign next_idx  = ptr_add(rd_ptr, 1);
    assign head_data = mem_data[rd_ptr];
    assign head_addr = mem_addr[rd_ptr];
    assign next_data = mem_data[next_idx];
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// AVR instruction fetch: prefetches pmem words and presents whole 1- or 2-word instructions.
// Define INST_FETCH_SKIP_EN to add c_skip for skip-type instructions.
module inst_fetch #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 3
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.master bus
);
    import growl_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] issue_adr_q;
    logic            inflight_q;
    logic [15:0]     head_data;
    logic [PC_W-1:0] head_addr;
    logic [15:0]     next_data;
    logic [CW-1:0]   count;
    logic            head_two;
    logic            valid_c;
    logic            take;
    logic [1:0]      pop_n;
    logic            re_c;
    int              occ_next;

`ifdef INST_FETCH_SKIP_EN
    logic skip_pend_q;
    logic skip_req;
    assign skip_req = bus.c_skip | skip_pend_q;
`endif

    always_comb begin
        head_two = is_two_word(head_data);
        valid_c  = (int'(count) >= 1 && !head_two) || (int'(count) >= 2 && head_two);
`ifdef INST_FETCH_SKIP_EN
        take     = valid_c && (!bus.c_stall || skip_req);
`else
        take     = valid_c && !bus.c_stall;
`endif
        pop_n    = take ? (head_two ? 2'd2 : 2'd1) : 2'd0;
        // A slot freed by this cycle's pop may be claimed by this cycle's read.
        occ_next = int'(count) - int'(pop_n) + int'(inflight_q) + 1;
        re_c     = !rst && !bus.c_pc_load && (occ_next <= DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            issue_adr_q <= '0;
            inflight_q  <= 1'b0;
        end else if (bus.c_pc_load) begin
            fetch_pc    <= bus.pc_load_val;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= re_c;
            if (re_c) begin
                fetch_pc    <= fetch_pc + PC_W'(1);
                issue_adr_q <= fetch_pc;
            end
        end
    end

`ifdef INST_FETCH_SKIP_EN
    always_ff @(posedge clk) begin
        if (rst || bus.c_pc_load) skip_pend_q <= 1'b0;
        else                      skip_pend_q <= skip_req && !valid_c;
    end
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.c_pc_load),
        .push      (inflight_q),
        .push_data (bus.pmem_dout),
        .push_addr (issue_adr_q),
        .pop_n     (pop_n),
        .head_data (head_data),
        .head_addr (head_addr),
        .next_data (next_data),
        .count     (count)
    );

    assign bus.pmem_adr      = fetch_pc;
    assign bus.pmem_re       = re_c;
    assign bus.inst_valid    = valid_c;
    assign bus.inst_out      = valid_c ? head_data : NOP_INST;
    assign bus.inst2_out     = (valid_c && head_two) ? next_data : NOP_INST;
    assign bus.inst_two_word = valid_c && head_two;
    assign bus.pc_out        = valid_c ? head_addr : '0;

endmodule
